packet_tx_arbiter: RTL and testbench

PACKET_TX_ARBITER -- requirements
Module: packet_tx_arbiter

---
 rtl/packet_tx_arbiter_pkg.sv | 23 ++
 rtl/packet_tx_arbiter_tx_wait_timer.sv | 29 ++
 rtl/packet_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_packet_tx_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_tx_arbiter_pkg.sv
// Shared types and constants for the packet transmit arbiter.
package packet_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_WAIT_START,
    ST_WAIT_END
  } arb_state_t;

  localparam int PID_W  = 4;
  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;

  localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
  localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
  localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
  localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
  localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;

endpackage

// File: rtl/packet_tx_arbiter_tx_wait_timer.sv
// Clearable 8-bit wait counter; tc flags the last cycle before LIMIT is reached.
module tx_wait_timer
  import packet_tx_arbiter_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count: this cycle's increment would bring the count to LIMIT.
  assign tc = en && (count == TC_VAL);

endmodule

// File: rtl/packet_tx_arbiter.sv
// Two-requester arbiter feeding one packet encoder. Optional ARB_ROUND_ROBIN_EN
// replaces fixed hs-over-tk priority with alternation on contention.
module packet_tx_arbiter
  import packet_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_req,
  input  logic [PID_W-1:0]  hs_pid,
  output logic              hs_grant,
  output logic              hs_done,
  input  logic              tk_req,
  input  logic [PID_W-1:0]  tk_pid,
  input  logic [ADDR_W-1:0] tk_addr,
  input  logic [ENDP_W-1:0] tk_endp,
  input  logic [DATA_W-1:0] tk_data,
  output logic              tk_grant,
  output logic              tk_done,
  output logic              enc_pktready,
  output logic [PID_W-1:0]  enc_pid,
  output logic [ADDR_W-1:0] enc_addr,
  output logic [ENDP_W-1:0] enc_endp,
  output logic [DATA_W-1:0] enc_data,
  input  logic              enc_gotpkt,
  input  logic              enc_sending,
  output logic              busy,
  output logic              err
);

  arb_state_t state, state_next;
  logic owner_hs;
  logic pick_hs;
  logic accept;
  logic timeout;
  logic finish;
  logic timer_tc;
  logic timer_clr;
  logic timer_en;

  assign accept = (state == ST_IDLE) && (hs_req || tk_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_hs;

  // Resets to "tk granted last" so hs wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_hs <= 1'b0;
    end else if (accept) begin
      last_hs <= pick_hs;
    end
  end

  assign pick_hs = hs_req && !(tk_req && last_hs);
`else
  assign pick_hs = hs_req;
`endif

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs_req || tk_req) state_next = ST_OFFER;
      end
      ST_OFFER: begin
        if (enc_gotpkt) begin
          state_next = ST_WAIT_START;
        end else if (timer_tc) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (enc_sending) begin
          state_next = ST_WAIT_END;
        end else if (timer_tc) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (!enc_sending) begin
          state_next = ST_IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Every state change restarts the count, so OFFER and WAIT_START each start at 0.
  assign timer_clr = (state_next != state);
  assign timer_en  = (state == ST_OFFER) || (state == ST_WAIT_START);

  tx_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(timer_clr),
    .en (timer_en),
    .tc (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner_hs <= 1'b0;
      hs_grant <= 1'b0;
      tk_grant <= 1'b0;
      hs_done  <= 1'b0;
      tk_done  <= 1'b0;
      err      <= 1'b0;
      enc_pid  <= '0;
      enc_addr <= '0;
      enc_endp <= '0;
      enc_data <= '0;
    end else begin
      state    <= state_next;
      hs_grant <= accept && pick_hs;
      tk_grant <= accept && !pick_hs;
      hs_done  <= finish && owner_hs;
      tk_done  <= finish && !owner_hs;
      err      <= timeout;
      if (accept) begin
        owner_hs <= pick_hs;
        if (pick_hs) begin
          enc_pid  <= hs_pid;
          enc_addr <= '0;
          enc_endp <= '0;
          enc_data <= '0;
        end else begin
          enc_pid  <= tk_pid;
          enc_addr <= tk_addr;
          enc_endp <= tk_endp;
          enc_data <= tk_data;
        end
      end
    end
  end

  assign enc_pktready = (state == ST_OFFER);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_packet_tx_arbiter;
  import packet_tx_arbiter_pkg::*;

  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hs_req;
  logic [PID_W-1:0]  hs_pid;
  logic              hs_grant, hs_done;
  logic              tk_req;
  logic [PID_W-1:0]  tk_pid;
  logic [ADDR_W-1:0] tk_addr;
  logic [ENDP_W-1:0] tk_endp;
  logic [DATA_W-1:0] tk_data;
  logic              tk_grant, tk_done;
  logic              enc_pktready;
  logic [PID_W-1:0]  enc_pid;
  logic [ADDR_W-1:0] enc_addr;
  logic [ENDP_W-1:0] enc_endp;
  logic [DATA_W-1:0] enc_data;
  logic              enc_gotpkt, enc_sending;
  logic              busy, err;

  always #5 clk = ~clk;

  packet_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_grant(hs_grant), .hs_done(hs_done),
    .tk_req(tk_req), .tk_pid(tk_pid), .tk_addr(tk_addr), .tk_endp(tk_endp),
    .tk_data(tk_data), .tk_grant(tk_grant), .tk_done(tk_done),
    .enc_pktready(enc_pktready), .enc_pid(enc_pid), .enc_addr(enc_addr),
    .enc_endp(enc_endp), .enc_data(enc_data), .enc_gotpkt(enc_gotpkt),
    .enc_sending(enc_sending), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 offered, 2 accepted/awaiting start, 3 sending.
  int                m_phase = 0;
  int                m_wait = 0;
  bit                m_owner_hs = 0;
  bit                m_last_hs = 0;
  bit                m_hs_grant, m_tk_grant, m_hs_done, m_tk_done, m_err;
  logic [PID_W-1:0]  m_pid = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ENDP_W-1:0] m_endp = '0;
  logic [DATA_W-1:0] m_data = '0;

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hs_wins;
    m_hs_grant = 0; m_tk_grant = 0; m_hs_done = 0; m_tk_done = 0; m_err = 0;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_owner_hs = 0; m_last_hs = 0;
      m_pid = '0; m_addr = '0; m_endp = '0; m_data = '0;
      return;
    end
    case (m_phase)
      0: if (hs_req || tk_req) begin
        hs_wins = hs_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (hs_req && tk_req) hs_wins = !m_last_hs;
`endif
        if (hs_wins) begin
          m_pid = hs_pid; m_addr = '0; m_endp = '0; m_data = '0; m_hs_grant = 1;
        end else begin
          m_pid = tk_pid; m_addr = tk_addr; m_endp = tk_endp; m_data = tk_data; m_tk_grant = 1;
        end
        m_owner_hs = hs_wins; m_last_hs = hs_wins; m_phase = 1; m_wait = 0;
      end
      1, 2: begin
        m_wait++;
        if ((m_phase == 1 && enc_gotpkt) || (m_phase == 2 && enc_sending)) begin
          m_phase = m_phase + 1; m_wait = 0;
        end else if (m_wait >= TO) begin
          m_phase = 0; m_err = 1;
        end
      end
      default: if (!enc_sending) begin
        m_phase = 0;
        if (m_owner_hs) m_hs_done = 1; else m_tk_done = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    check1("hs_grant", hs_grant, m_hs_grant);
    check1("tk_grant", tk_grant, m_tk_grant);
    check1("hs_done", hs_done, m_hs_done);
    check1("tk_done", tk_done, m_tk_done);
    check1("err", err, m_err);
    check1("busy", busy, m_phase != 0);
    check1("enc_pktready", enc_pktready, m_phase == 1);
    checkv("enc_pid", 64'(enc_pid), 64'(m_pid));
    checkv("enc_addr", 64'(enc_addr), 64'(m_addr));
    checkv("enc_endp", 64'(enc_endp), 64'(m_endp));
    checkv("enc_data", enc_data, m_data);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic serve(int pre, int n);
    repeat (pre) tick();
    enc_gotpkt = 1; tick();
    enc_gotpkt = 0; enc_sending = 1;
    repeat (n) tick();
    enc_sending = 0; tick();
  endtask

  initial begin
    int tkg;
    rst = 1; hs_req = 0; hs_pid = '0; tk_req = 0; tk_pid = '0; tk_addr = '0;
    tk_endp = '0; tk_data = '0; enc_gotpkt = 0; enc_sending = 0;
    tick(); tick();
    check1("reset_busy", busy, 1'b0);
    checkv("reset_enc_pid", 64'(enc_pid), 64'd0);
    rst = 0;

    // Handshake packet with 8 sending cycles.
    hs_req = 1; hs_pid = PID_ACK; tick();
    check1("hs_grant_lat", hs_grant, 1'b1);
    checkv("hs_enc_pid", 64'(enc_pid), 64'h2);
    checkv("hs_enc_data", enc_data, 64'd0);
    hs_req = 0; hs_pid = '0;
    serve(1, 8);
    check1("hs_done_end", hs_done, 1'b1);
    check1("hs_done_busy", busy, 1'b0);

    // Token packet, fields stable through 11 sending cycles.
    tk_req = 1; tk_pid = PID_OUT; tk_addr = 7'h6D; tk_endp = 4'hD;
    tk_data = 64'hDEAD_BEEF_0123_4567; tick();
    check1("tk_grant_lat", tk_grant, 1'b1);
    checkv("tk_enc_addr", 64'(enc_addr), 64'h6D);
    checkv("tk_enc_endp", 64'(enc_endp), 64'hD);
    tk_req = 0; tk_addr = 7'h11; tk_endp = 4'h2;
    serve(0, 11);
    check1("tk_done_end", tk_done, 1'b1);
    checkv("tk_addr_stable", 64'(enc_addr), 64'h6D);

    // Simultaneous requests.
    hs_req = 1; hs_pid = PID_NAK; tk_req = 1; tk_pid = PID_IN; tk_addr = 7'h05; tk_endp = 4'h1;
    tick();
    check1("both_hs_first", hs_grant, 1'b1);
    check1("both_tk_not_first", tk_grant, 1'b0);
    serve(0, 2);
`ifdef ARB_ROUND_ROBIN_EN
    tick();
    check1("rr_tk_second", tk_grant, 1'b1);
    serve(0, 2);
    tick();
    check1("rr_hs_third", hs_grant, 1'b1);
    hs_req = 0; tk_req = 0;
    serve(0, 2);
`else
    hs_req = 0; tick();
    check1("fixed_tk_second", tk_grant, 1'b1);
    tk_req = 0;
    serve(0, 2);
`endif

    // Encoder never accepts: timeout after TO offer cycles.
    hs_req = 1; hs_pid = PID_ACK; tick();
    hs_req = 0;
    repeat (TO - 1) tick();
    check1("to_still_offer", enc_pktready, 1'b1);
    tick();
    check1("to_err", err, 1'b1);
    check1("to_pktready", enc_pktready, 1'b0);
    check1("to_busy", busy, 1'b0);
    check1("to_no_done", hs_done, 1'b0);

    // Reset mid-packet with a pending token request.
    tk_req = 1; tk_pid = PID_DATA0; tk_addr = 7'h33; tk_endp = 4'h7; tk_data = 64'h55;
    tick();
    enc_gotpkt = 1; tick();
    enc_gotpkt = 0; enc_sending = 1; tick(); tick(); tick();
    rst = 1; enc_sending = 0; tick();
    check1("rst_busy", busy, 1'b0);
    checkv("rst_enc_addr", 64'(enc_addr), 64'd0);
    checkv("rst_enc_data", enc_data, 64'd0);
    rst = 0; tick();
    check1("rst_then_grant", tk_grant, 1'b1);
    tk_req = 0;
    serve(0, 1);

    // Token request pulsed while a handshake packet is in flight is dropped.
    tkg = 0;
    hs_req = 1; hs_pid = PID_NAK; tick();
    hs_req = 0; enc_gotpkt = 1; tk_req = 1; tick();
    tkg += int'(tk_grant);
    tk_req = 0; enc_gotpkt = 0; enc_sending = 1;
    repeat (3) begin tick(); tkg += int'(tk_grant); end
    enc_sending = 0;
    repeat (4) begin tick(); tkg += int'(tk_grant); end
    checkv("withdrawn_tk_grants", 64'(tkg), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (hs_req) hs_req = ($urandom_range(0, 7) != 0);
      else begin hs_req = ($urandom_range(0, 3) == 0); hs_pid = 4'($urandom); end
      if (tk_req) tk_req = ($urandom_range(0, 7) != 0);
      else begin
        tk_req = ($urandom_range(0, 3) == 0);
        tk_pid = 4'($urandom); tk_addr = 7'($urandom); tk_endp = 4'($urandom);
        tk_data = {$urandom, $urandom};
      end
      enc_gotpkt = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) enc_sending = ~enc_sending;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
